strobe_period_meter: RTL and testbench

Measures the strobe interval produced by `counter_with_strobe`: counts `enable`-qualified ticks between successive single-cycle strobe pulses and reports the period, a validity pulse, overflow and a lock indication. It sits downstream of a strobe generator, either in the same clock domain for self-check or as a rate monitor. Given a generator programmed with `reset_value = N` and the same `enable`, it reports N.

---
 rtl/counter_pkg.sv | 20 ++
 rtl/saturating_tick_counter.sv | 32 +++
 rtl/strobe_period_meter.sv | 130 +++++++++++++
 tb/tb_strobe_period_meter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the strobe generator / period meter family:
// FSM state encodings and a constant-function log2 for sizing counters.
package counter_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_SEEK    = 1'b0;
  localparam state_t ST_MEASURE = 1'b1;

  // Bits needed to hold values 0..v-1 (minimum 1).
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/saturating_tick_counter.sv
// WIDTH-bit tick counter. `value` is the count including this cycle's `inc`,
// clamped at all-ones; `sat` flags an increment that would have gone past it.
module saturating_tick_counter #(
  parameter int WIDTH = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             zero,
  output logic [WIDTH-1:0] value,
  output logic             sat
);
  import counter_pkg::*;

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    sat   = inc && (cnt_q == MAX_VAL);
    value = sat ? cnt_q : cnt_q + {{(WIDTH-1){1'b0}}, inc};
    // `zero` discards the running sum so the next interval starts clean.
    cnt_d = zero ? '0 : value;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/strobe_period_meter.sv
// Measures enable-qualified ticks between strobe pulses; reports the period,
// a one-cycle valid pulse, sticky overflow and a lock indication.
module strobe_period_meter #(
  parameter int WIDTH      = 25,
  parameter int LOCK_COUNT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             strobe_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             overflow,
  output logic             locked
);
  import counter_pkg::*;

  localparam int MATCH_W = clog2(LOCK_COUNT + 1);
  localparam logic [MATCH_W-1:0] LOCK_TGT = MATCH_W'(LOCK_COUNT);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   period_q, period_d;
  logic               period_valid_q, period_valid_d;
  logic               overflow_q, overflow_d;
  logic               locked_q, locked_d;
  logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
  logic               ovf_run_q, ovf_run_d;
  logic               period_ok_q, period_ok_d;

  logic               cnt_zero;
  logic [WIDTH-1:0]   cur;
  logic               cnt_sat;
  logic               ovf_now;

  saturating_tick_counter #(.WIDTH(WIDTH)) u_ticks (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (enable),
    .zero  (cnt_zero),
    .value (cur),
    .sat   (cnt_sat)
  );

  assign ovf_now = ovf_run_q | cnt_sat;

  always_comb begin
    state_d        = state_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    overflow_d     = overflow_q;
    locked_d       = locked_q;
    match_cnt_d    = match_cnt_q;
    ovf_run_d      = ovf_run_q;
    period_ok_d    = period_ok_q;
    cnt_zero       = 1'b1;

    if (clear) begin
      state_d     = ST_SEEK;
      period_d    = '0;
      overflow_d  = 1'b0;
      locked_d    = 1'b0;
      match_cnt_d = '0;
      ovf_run_d   = 1'b0;
      period_ok_d = 1'b0;
    end else begin
      case (state_q)
        ST_SEEK: begin
          if (strobe_in) state_d = ST_MEASURE;
        end
        ST_MEASURE: begin
          cnt_zero = strobe_in;
          if (strobe_in) begin
            ovf_run_d = 1'b0;
            if (ovf_now) begin
              // An overflowed interval breaks the lock chain entirely.
              overflow_d  = 1'b1;
              match_cnt_d = '0;
              locked_d    = 1'b0;
              period_ok_d = 1'b0;
            end else begin
              period_d       = cur;
              period_valid_d = 1'b1;
              overflow_d     = 1'b0;
              period_ok_d    = 1'b1;
              if (period_ok_q && (cur == period_q))
                match_cnt_d = (match_cnt_q >= LOCK_TGT) ? match_cnt_q
                                                        : match_cnt_q + 1'b1;
              else
                match_cnt_d = {{(MATCH_W-1){1'b0}}, 1'b1};
              locked_d = (match_cnt_d >= LOCK_TGT);
            end
          end else if (cnt_sat) begin
            ovf_run_d  = 1'b1;
            overflow_d = 1'b1;
          end
        end
        default: state_d = ST_SEEK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_SEEK;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      locked_q       <= 1'b0;
      match_cnt_q    <= '0;
      ovf_run_q      <= 1'b0;
      period_ok_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      overflow_q     <= overflow_d;
      locked_q       <= locked_d;
      match_cnt_q    <= match_cnt_d;
      ovf_run_q      <= ovf_run_d;
      period_ok_q    <= period_ok_d;
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign overflow     = overflow_q;
  assign locked       = locked_q;

endmodule

// File: tb/tb_strobe_period_meter.sv
// Randomised and directed bench for strobe_period_meter against an
// interval-counting reference model (unbounded integer tick counts).
module tb_strobe_period_meter;

  localparam int W    = 5;
  localparam int LOCK = 2;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic         enable;
  logic         strobe_in;
  logic [W-1:0] period;
  logic         period_valid;
  logic         overflow;
  logic         locked;

  strobe_period_meter #(.WIDTH(W), .LOCK_COUNT(LOCK)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .enable       (enable),
    .strobe_in    (strobe_in),
    .period       (period),
    .period_valid (period_valid),
    .overflow     (overflow),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: counts ticks as plain integers, keeps the length of the
  // trailing run of identical reported periods.
  bit measuring;
  int ticks;
  int exp_period;
  bit exp_valid, exp_ovf, have_period;
  int run_len;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    measuring = 0; ticks = 0; exp_period = 0; exp_valid = 0;
    exp_ovf = 0; have_period = 0; run_len = 0;
  endtask

  task automatic model_step(input bit clr, input bit en, input bit stb);
    exp_valid = 0;
    if (clr) begin
      model_reset();
    end else if (!measuring) begin
      if (stb) begin
        measuring = 1;
        ticks = 0;
      end
    end else begin
      ticks += int'(en);
      if (stb) begin
        if (ticks > MAXV) begin
          exp_ovf = 1; run_len = 0; have_period = 0;
        end else begin
          run_len = (have_period && ticks == exp_period) ? run_len + 1 : 1;
          exp_period = ticks; exp_valid = 1; exp_ovf = 0; have_period = 1;
        end
        ticks = 0;
      end else if (ticks > MAXV) begin
        exp_ovf = 1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check($sformatf("%s.period", tag), 32'(period), 32'(exp_period));
    check($sformatf("%s.valid", tag), 32'(period_valid), 32'(exp_valid));
    check($sformatf("%s.overflow", tag), 32'(overflow), 32'(exp_ovf));
    check($sformatf("%s.locked", tag), 32'(locked), 32'(run_len >= LOCK));
  endtask

  // Inputs are applied just after a falling edge and checked at the next one.
  task automatic cycle(input bit clr, input bit en, input bit stb, input string tag);
    clear = clr; enable = en; strobe_in = stb;
    @(posedge clk);
    model_step(clr, en, stb);
    @(negedge clk);
    check_outputs(tag);
  endtask

  // Generator model: strobe on the N-th enabled tick, enable every `div` cycles.
  task automatic gen_phase(input int n, input int div, input int strobes, input string tag);
    int gc = 0;
    int seen = 0;
    for (int c = 0; c < 2000 && seen < strobes; c++) begin
      bit en, stb;
      en  = (c % div) == 0;
      stb = en && (gc == n - 1);
      if (stb) begin gc = 0; seen++; end
      else if (en) gc++;
      cycle(1'b0, en, stb, tag);
    end
  endtask

  initial begin
    int rem = 0;
    int lastl = 4;
    int len;
    int r;
    bit full = 1;

    rst_n = 1'b0; clear = 1'b0; enable = 1'b0; strobe_in = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("reset");
    rst_n = 1'b1;

    gen_phase(5, 1, 6, "steady");
    gen_phase(4, 3, 5, "gated");
    gen_phase(5, 1, 4, "chg5");
    gen_phase(7, 1, 4, "chg7");

    cycle(1'b0, 1'b1, 1'b1, "ovf");
    for (int i = 0; i < 39; i++) cycle(1'b0, 1'b1, 1'b0, "ovf");
    cycle(1'b0, 1'b1, 1'b1, "ovf_stb");
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, "ovf6");
    cycle(1'b0, 1'b1, 1'b1, "ovf6_stb");

    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b1, "b2b");

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, "en_low");
      cycle(1'b0, 1'b0, 1'b1, "en_low_stb");
    end

    cycle(1'b1, 1'b1, 1'b1, "clr_stb");
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, "after_clr");

    for (int c = 0; c < 3000; c++) begin
      if (rem == 0) begin
        r = $urandom_range(0, 99);
        if (r < 55)      len = lastl;
        else if (r < 90) len = $urandom_range(1, 10);
        else             len = $urandom_range(30, 45);
        if (len < 20) lastl = len;
        rem = len;
        if ($urandom_range(0, 9) == 0) full = !full;
      end
      cycle($urandom_range(0, 599) == 0, full ? 1'b1 : ($urandom_range(0, 3) != 0),
            rem == 1, "rand");
      rem--;
    end

    gen_phase(5, 1, 3, "pre_rst");
    cycle(1'b0, 1'b1, 1'b0, "pre_rst");
    cycle(1'b0, 1'b1, 1'b0, "pre_rst");
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    gen_phase(3, 1, 4, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
